signal_speed_ctrl: RTL
======================

SIGNAL_SPEED_CTRL -- requirements
Module: signal_speed_ctrl

Interface
REQ-001 SHALL have parameter TW, default 6: width of the time-remaining field and counter, in seconds.
REQ-002 SHALL have parameter SW, default 6: width of the speed input.
REQ-003 SHALL have parameter DW, default 14: width of the distance field and counter.
REQ-004 SHALL have parameter PW, default 10: width of the duty output.
REQ-005 SHALL have parameters DUTY_HOLD (default 512) and DUTY_SLOW (default 256): duty codes driven for advisories HOLD and SLOW.
REQ-006 SHALL have port clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-007 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-008 SHALL have port start, input, 1 bit: level; arms the controller while high.
REQ-009 SHALL have port msg_valid, input, 1 bit: one-cycle strobe qualifying msg_colour, msg_time and dist_init.
REQ-010 SHALL have port msg_colour, input, 2 bits: signal colour; 00 = RED, 01 = GREEN, others treated as RED.
REQ-011 SHALL have port msg_time, input, TW bits: seconds until the signal changes.
REQ-012 SHALL have port dist_init, input, DW bits: distance to the signal when the message is received.
REQ-013 SHALL have port speed, input, SW bits: distance units per second.
REQ-014 SHALL have port seconds_tick, input, 1 bit: one-cycle pulse, once per second.
REQ-015 SHALL have outputs time_rem (TW bits) and dist_rem (DW bits): the live counters.
REQ-016 SHALL have output advise, 2 bits: 00 = STOP, 01 = SLOW, 10 = HOLD.
REQ-017 SHALL have output duty, PW bits: PWM width command.
REQ-018 SHALL have output busy, 1 bit: high in states MULT, DECIDE and TRACK.
REQ-019 SHALL have output reached, 1 bit: one-cycle pulse when dist_rem reaches 0.

Function
REQ-020 SHALL implement states IDLE, ARMED, MULT, DECIDE, TRACK and DONE.
REQ-021 IDLE SHALL go to ARMED when start=1; msg_valid SHALL be ignored in IDLE.
REQ-022 ARMED, on msg_valid, SHALL load time_rem←msg_time, dist_rem←dist_init and the colour register, then go to MULT.
REQ-023 MULT SHALL capture time_rem and speed on entry and compute their product (TW+SW bits) by shift-add over exactly TW cycles, then go to DECIDE.
REQ-024 DECIDE SHALL last one cycle and SHALL compare the product with zero-extended dist_rem; equality counts as product ≥ dist_rem.
REQ-025 DECIDE, for GREEN, SHALL give HOLD when product ≥ dist_rem, else SLOW; for RED, SHALL give SLOW when product ≥ dist_rem, else HOLD.
REQ-026 DECIDE SHALL register advise and duty at its closing edge, then go to TRACK.
REQ-027 The msg_valid edge plus TW+2 cycles SHALL be the first cycle in which the new advise is visible.
REQ-028 On seconds_tick in MULT, DECIDE or TRACK: time_rem−=1 and dist_rem−=speed, both saturating at 0.
REQ-029 The MULT operands SHALL stay those captured at MULT entry; DECIDE SHALL use the current dist_rem.
REQ-030 TRACK SHALL go to MULT on the cycle after a seconds_tick, to re-evaluate with the updated counters.
REQ-031 When dist_rem becomes 0: pulse reached for one cycle, go to DONE, advise=STOP, duty=0.
REQ-032 When time_rem becomes 0 and dist_rem≠0: go to ARMED; advise and duty SHALL hold their values.
REQ-033 msg_valid in MULT, DECIDE or TRACK SHALL reload the counters and colour and restart MULT, aborting any multiply in progress.
REQ-034 msg_valid coincident with seconds_tick: the load SHALL win and no decrement SHALL occur that cycle.
REQ-035 DONE SHALL return to IDLE when start=0.
REQ-036 start=0 in any state SHALL give IDLE on the next edge with advise=STOP and duty=0; the counters SHALL hold.

Reset
REQ-037 reset=0 SHALL immediately force state IDLE, time_rem=0, dist_rem=0, advise=STOP, duty=0, busy=0 and reached=0, regardless of clock.
REQ-038 Reset asserted mid-MULT SHALL discard the partial product; no advise update SHALL follow reset release.

Structure
REQ-039 A shared package/header signal_ctrl_pkg SHALL hold the state encodings, the advise codes (STOP/SLOW/HOLD), the colour codes and the default duty constants.
REQ-040 The shift-add multiplier SHALL be a separate sub-module seq_mult, parametrised by TW and SW, with start/ready handshake and a synchronous abort input.

Verification (defaults)
REQ-041 SHALL test: GREEN, time 10, speed 5, dist 40 -> product 50, advise HOLD, duty 512, visible 8 cycles after msg_valid.
REQ-042 SHALL test: RED, time 10, speed 5, dist 100 -> HOLD; same with dist 30 -> SLOW, duty 256.
REQ-043 SHALL test: speed 5, dist 12, three ticks -> dist 7, 2, 0; reached pulses once; DONE, STOP, duty 0.
REQ-044 SHALL test: time 2, dist 500, two ticks -> time_rem 0, state ARMED, busy 0, duty still 512.
REQ-045 SHALL test: msg_valid coincident with tick during MULT cycle 3 -> counters equal the new message with no decrement; advise updates 8 cycles later.
REQ-046 SHALL test: reset low mid-MULT -> all outputs 0 within the same cycle; no advise change after release.

Source files
------------

// File: rtl/signal_ctrl_pkg.sv
// Shared encodings for the signal speed advisory controller: FSM states,
// advisory codes, colour codes and the default duty commands.
package signal_ctrl_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_ARMED  = 3'd1;
  localparam logic [2:0] ST_MULT   = 3'd2;
  localparam logic [2:0] ST_DECIDE = 3'd3;
  localparam logic [2:0] ST_TRACK  = 3'd4;
  localparam logic [2:0] ST_DONE   = 3'd5;

  localparam logic [1:0] ADV_STOP = 2'b00;
  localparam logic [1:0] ADV_SLOW = 2'b01;
  localparam logic [1:0] ADV_HOLD = 2'b10;

  localparam logic [1:0] COL_RED   = 2'b00;
  localparam logic [1:0] COL_GREEN = 2'b01;

  localparam int DUTY_HOLD_DEF = 512;
  localparam int DUTY_SLOW_DEF = 256;

  // can_reach: distance coverable before the signal changes (product >= dist)
  function automatic logic [1:0] advise_for(input logic green, input logic can_reach);
    if (green) return can_reach ? ADV_HOLD : ADV_SLOW;
    return can_reach ? ADV_SLOW : ADV_HOLD;
  endfunction

endpackage

// File: rtl/seq_mult.sv
// Shift-add unsigned multiplier: operands captured on start, product ready
// after exactly TW shift-add cycles; abort drops any multiply in progress.
module seq_mult #(
  parameter int TW = 6,
  parameter int SW = 6
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  input  logic [TW-1:0]      a,
  input  logic [SW-1:0]      b,
  output logic [TW+SW-1:0]   product,
  output logic               ready
);

  localparam int CW = $clog2(TW + 1);

  logic [TW-1:0]    a_sh;
  logic [TW+SW-1:0] b_sh;
  logic [CW-1:0]    cnt;

  // start wins over abort so a reload always restarts cleanly
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      a_sh    <= '0;
      b_sh    <= '0;
      cnt     <= '0;
      product <= '0;
      ready   <= 1'b0;
    end else if (start) begin
      a_sh    <= a;
      b_sh    <= {{TW{1'b0}}, b};
      cnt     <= CW'(TW);
      product <= '0;
      ready   <= 1'b0;
    end else if (abort) begin
      cnt     <= '0;
      ready   <= 1'b0;
    end else if (cnt != '0) begin
      if (a_sh[0]) product <= product + b_sh;
      a_sh  <= a_sh >> 1;
      b_sh  <= b_sh << 1;
      cnt   <= cnt - CW'(1);
      ready <= (cnt == CW'(1));
    end
  end

endmodule

// File: rtl/signal_speed_ctrl.sv
// Signal-approach speed advisory: multiplies time-to-change by speed and
// compares with remaining distance to choose HOLD/SLOW/STOP and a duty code.
//
// state   | meaning
// IDLE    | disarmed, waiting for start
// ARMED   | waiting for a signal message
// MULT    | time_rem * speed in progress
// DECIDE  | compare product with dist_rem, register advise/duty
// TRACK   | advisory active, waiting for the next seconds tick
// DONE    | signal reached, waiting for start to drop
module signal_speed_ctrl
  import signal_ctrl_pkg::*;
#(
  parameter int TW        = 6,
  parameter int SW        = 6,
  parameter int DW        = 14,
  parameter int PW        = 10,
  parameter int DUTY_HOLD = DUTY_HOLD_DEF,
  parameter int DUTY_SLOW = DUTY_SLOW_DEF
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          start,
  input  logic          msg_valid,
  input  logic [1:0]    msg_colour,
  input  logic [TW-1:0] msg_time,
  input  logic [DW-1:0] dist_init,
  input  logic [SW-1:0] speed,
  input  logic          seconds_tick,
  output logic [TW-1:0] time_rem,
  output logic [DW-1:0] dist_rem,
  output logic [1:0]    advise,
  output logic [PW-1:0] duty,
  output logic          busy,
  output logic          reached
);

  logic [2:0]       state;
  logic             green;
  logic [TW-1:0]    time_dec;
  logic [DW-1:0]    dist_dec;
  logic             active, load, tick_act;
  logic             mult_start, mult_abort, mult_ready, can_reach;
  logic [TW-1:0]    mult_a;
  logic [TW+SW-1:0] product;
  logic [1:0]       adv_new;

  always_comb begin
    time_dec   = (time_rem == '0) ? '0 : time_rem - TW'(1);
    dist_dec   = (dist_rem > DW'(speed)) ? dist_rem - DW'(speed) : '0;
    active     = (state == ST_MULT) || (state == ST_DECIDE) || (state == ST_TRACK);
    load       = start && msg_valid && (active || (state == ST_ARMED));
    tick_act   = start && seconds_tick && active && !msg_valid;
    // operands are the values the counters take on the edge that enters MULT
    mult_start = load || (tick_act && (state == ST_TRACK) && (dist_dec != '0) && (time_dec != '0));
    mult_abort = !start || (tick_act && ((dist_dec == '0) || (time_dec == '0)));
    mult_a     = load ? msg_time : time_dec;
    can_reach  = ({{DW{1'b0}}, product} >= {{(TW+SW){1'b0}}, dist_rem});
    adv_new    = advise_for(green, can_reach);
  end

  assign busy = active;

  seq_mult #(.TW(TW), .SW(SW)) u_mult (
    .clock   (clock),
    .reset   (reset),
    .start   (mult_start),
    .abort   (mult_abort),
    .a       (mult_a),
    .b       (speed),
    .product (product),
    .ready   (mult_ready)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      time_rem <= '0;
      dist_rem <= '0;
      green    <= 1'b0;
      advise   <= ADV_STOP;
      duty     <= '0;
      reached  <= 1'b0;
    end else begin
      reached <= 1'b0;
      if (!start) begin
        state  <= ST_IDLE;
        advise <= ADV_STOP;
        duty   <= '0;
      end else if (load) begin
        time_rem <= msg_time;
        dist_rem <= dist_init;
        green    <= (msg_colour == COL_GREEN);
        state    <= ST_MULT;
      end else begin
        if (tick_act) begin
          time_rem <= time_dec;
          dist_rem <= dist_dec;
        end
        if (tick_act && (dist_dec == '0)) begin
          reached <= 1'b1;
          state   <= ST_DONE;
          advise  <= ADV_STOP;
          duty    <= '0;
        end else if (tick_act && (time_dec == '0)) begin
          state <= ST_ARMED;
        end else begin
          case (state)
            ST_IDLE:   state <= ST_ARMED;
            ST_ARMED:  state <= ST_ARMED;
            ST_MULT:   if (mult_ready) state <= ST_DECIDE;
            ST_DECIDE: begin
              advise <= adv_new;
              duty   <= (adv_new == ADV_HOLD) ? PW'(DUTY_HOLD) : PW'(DUTY_SLOW);
              state  <= ST_TRACK;
            end
            ST_TRACK:  if (tick_act) state <= ST_MULT;
            ST_DONE:   state <= ST_DONE;
            default:   state <= ST_IDLE;
          endcase
        end
      end
    end
  end

endmodule
